// File: rtl/ddr3_wr_ch_requester.sv
// ddr3_wr_ch_requester: requests the arbiter once a full burst sits in the channel FIFO, then streams it as write commands and data to the DDR3 app interface
module ddr3_wr_ch_requester #(
  parameter int BURST_LEN = 64,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W = 10,
  parameter int ADDR_STEP = 8,
  parameter int BASE_ADDR = 0,
  parameter int REGION_LEN = 1 << 20
) (
  input  logic              I_clk,
  input  logic              I_Rst,
  input  logic [CNT_W-1:0]  I_fifo_cnt,
  input  logic [DATA_W-1:0] I_fifo_data,
  output logic              O_fifo_rden,
  output logic              O_ch_req,
  input  logic              I_ch_vaild,
  output logic              O_ch_start,
  output logic              O_ch_end,
  output logic              O_app_en,
  output logic [2:0]        O_app_cmd,
  output logic [ADDR_W-1:0] O_app_addr,
  input  logic              I_app_rdy,
  output logic              O_app_wdf_wren,
  output logic [DATA_W-1:0] O_app_wdf_data,
  output logic              O_app_wdf_end,
  input  logic              I_app_wdf_rdy
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(longint'(BASE_ADDR) + longint'(REGION_LEN));
  localparam logic [ADDR_W:0] STEP = (ADDR_W+1)'(ADDR_STEP);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_BURST, S_END} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cmd_cnt, dat_cnt, cmd_cnt_nxt, dat_cnt_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0] addr_inc;
  logic cmd_fire, dat_fire;
  always_ff @(posedge I_clk)
    state <= I_Rst ? S_IDLE : state_nxt;
  // leave the burst on the cycle both sides accept their last beat, so a full-rate burst takes exactly BURST_LEN cycles
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = I_fifo_cnt >= THRESH ? S_WAIT : S_IDLE;
      S_WAIT:  state_nxt = I_ch_vaild ? S_START : S_WAIT;
      S_START: state_nxt = S_BURST;
      S_BURST: state_nxt = (cmd_cnt_nxt == LAST && dat_cnt_nxt == LAST) ? S_END : S_BURST;
      S_END:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    O_ch_req = !I_Rst && state == S_IDLE && I_fifo_cnt >= THRESH;
    O_ch_start = state == S_START;
    O_ch_end = state == S_END;
    O_app_en = state == S_BURST && cmd_cnt < LAST;
    O_app_wdf_wren = state == S_BURST && dat_cnt < LAST;
    O_app_wdf_end = O_app_wdf_wren;
    O_app_cmd = 3'b000;
    O_app_addr = addr;
    O_app_wdf_data = I_fifo_data;
    cmd_fire = O_app_en && I_app_rdy;
    dat_fire = O_app_wdf_wren && I_app_wdf_rdy;
    O_fifo_rden = dat_fire;
    cmd_cnt_nxt = cmd_cnt + CW'(cmd_fire);
    dat_cnt_nxt = dat_cnt + CW'(dat_fire);
    addr_inc = {1'b0, addr} + STEP;
  end
  always_ff @(posedge I_clk) begin
    if (I_Rst || state == S_END) begin
      cmd_cnt <= '0;
      dat_cnt <= '0;
    end else begin
      cmd_cnt <= cmd_cnt_nxt;
      dat_cnt <= dat_cnt_nxt;
    end
  end
  // region size is a whole number of bursts, so the wrap always lands between bursts
  always_ff @(posedge I_clk) begin
    if (I_Rst) addr <= BASE;
    else if (cmd_fire) addr <= addr_inc == LIMIT ? BASE : addr_inc[ADDR_W-1:0];
  end
endmodule

// File: tb/tb_ddr3_wr_ch_requester.sv
// tb_ddr3_wr_ch_requester: scoreboard bench; the driver queues expected addresses and data, a negedge monitor pops and compares each accepted beat
module tb_ddr3_wr_ch_requester;
  localparam int BL = 64, AW = 28, DW = 128, CW = 10, STEP = 8, REG = 1024;
  logic clk = 0, rst = 1;
  logic [CW-1:0] fifo_cnt = '0;
  logic [DW-1:0] fifo_data = '0;
  logic fifo_rden, ch_req, ch_start, ch_end, app_en, wren, wdf_end;
  logic ch_vaild = 0, app_rdy = 0, wdf_rdy = 0;
  logic [2:0] app_cmd;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] wdf_data;
  int checks = 0, failures = 0;
  int n_req = 0, n_start = 0, n_end = 0, n_cmd = 0, n_dat = 0;
  int rdy_pct = 100, wdf_pct = 100, seq = 0;
  logic pop_flag = 0;
  logic [DW-1:0] fifo_q[$], exp_dat[$];
  logic [AW-1:0] exp_addr[$];
  logic prev_req = 0, prev_start = 0, prev_end = 0, prev_cmd_stall = 0, prev_dat_stall = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  always #5 clk = ~clk;

  ddr3_wr_ch_requester #(.BURST_LEN(BL), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW),
    .ADDR_STEP(STEP), .BASE_ADDR(0), .REGION_LEN(REG)) dut (
    .I_clk(clk), .I_Rst(rst), .I_fifo_cnt(fifo_cnt), .I_fifo_data(fifo_data),
    .O_fifo_rden(fifo_rden), .O_ch_req(ch_req), .I_ch_vaild(ch_vaild),
    .O_ch_start(ch_start), .O_ch_end(ch_end), .O_app_en(app_en), .O_app_cmd(app_cmd),
    .O_app_addr(app_addr), .I_app_rdy(app_rdy), .O_app_wdf_wren(wren),
    .O_app_wdf_data(wdf_data), .O_app_wdf_end(wdf_end), .I_app_wdf_rdy(wdf_rdy));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void fifo_upd();
    fifo_cnt = CW'(fifo_q.size());
    fifo_data = fifo_q.size() > 0 ? fifo_q[0] : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_flag && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_flag = 0;
    app_rdy = $urandom_range(99) < rdy_pct;
    wdf_rdy = $urandom_range(99) < wdf_pct;
    fifo_upd();
  endtask

  task automatic push_words(input int n);
    logic [DW-1:0] w;
    for (int j = 0; j < n; j++) begin
      w = {32'(seq), 32'hA5A5_0000 + 32'(seq), ~32'(seq), 32'(seq) * 32'd7};
      fifo_q.push_back(w);
      exp_dat.push_back(w);
      seq++;
    end
    fifo_upd();
  endtask

  // monitor: samples at negedge, scoreboards every accepted beat
  always @(negedge clk) begin
    if (prev_cmd_stall) begin
      chk("cmd_hold_en", app_en, 1);
      chk("cmd_hold_addr", app_addr, prev_addr);
    end
    if (prev_dat_stall) begin
      chk("dat_hold_wren", wren, 1);
      chk("dat_hold_data", wdf_data, prev_data);
    end
    if (app_en && app_rdy) begin
      n_cmd++;
      chk("cmd_expected", exp_addr.size() > 0, 1);
      if (exp_addr.size() > 0) chk("cmd_addr", app_addr, exp_addr.pop_front());
      chk("cmd_code", app_cmd, 3'b000);
    end
    if (wren && wdf_rdy) begin
      n_dat++;
      chk("dat_expected", exp_dat.size() > 0, 1);
      if (exp_dat.size() > 0) chk("dat_word", wdf_data, exp_dat.pop_front());
      chk("dat_wdf_end", wdf_end, 1);
    end
    if (fifo_rden || (wren && wdf_rdy)) chk("fifo_rden", fifo_rden, wren && wdf_rdy);
    if (ch_req) begin n_req++; chk("req_pulse", prev_req, 0); end
    if (ch_start) begin n_start++; n_cmd = 0; n_dat = 0; chk("start_pulse", prev_start, 0); end
    if (ch_end) begin
      n_end++;
      chk("end_pulse", prev_end, 0);
      chk("end_cmd_beats", n_cmd, BL);
      chk("end_dat_beats", n_dat, BL);
    end
    prev_req = ch_req;
    prev_start = ch_start;
    prev_end = ch_end;
    prev_cmd_stall = app_en && !app_rdy && !rst;
    prev_dat_stall = wren && !wdf_rdy && !rst;
    prev_addr = app_addr;
    prev_data = wdf_data;
    pop_flag = fifo_rden;
  end

  task automatic run_burst(input int gd, input int drop_at, input int rst_at,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a_after);
    int i, k, r0, s0, e0;
    r0 = n_req; s0 = n_start; e0 = n_end;
    for (int j = 0; j < BL; j++) exp_addr.push_back(a0 + AW'(j * STEP));
    i = 0;
    while (n_req == r0 && i < 200) begin step(); i++; end
    chk("req_seen", n_req - r0, 1);
    if (n_req == r0) return;
    chk("req_latency", i, 1);
    chk("wait_gnt_quiet", {fifo_rden, ch_req, ch_start, ch_end, app_en, wren}, 0);
    repeat (gd - 1) step();
    ch_vaild = 1;
    step();
    chk("start_latency", ch_start, 1);
    step();
    chk("first_beat", {ch_start, app_en, wren}, 3'b011);
    k = 0;
    while (!ch_end && k < 3000) begin
      if (n_cmd >= drop_at) ch_vaild = 0;
      if (rst_at >= 0 && n_cmd >= rst_at) begin
        rst = 1;
        ch_vaild = 0;
        step();
        chk("rst_outputs", {fifo_rden, ch_req, ch_start, ch_end, app_en, wren, wdf_end}, 0);
        chk("rst_addr", app_addr, 0);
        rst = 0;
        exp_addr.delete();
        r0 = n_req;
        repeat (5) step();
        chk("rst_no_end", n_end - e0, 0);
        chk("rst_no_req_short_fifo", n_req - r0, 0);
        return;
      end
      step();
      k++;
    end
    chk("end_seen", ch_end, 1);
    if (rdy_pct == 100 && wdf_pct == 100) chk("end_latency", k, BL);
    ch_vaild = 0;
    step();
    chk("idle_addr", app_addr, a_after);
    chk("idle_quiet", {fifo_rden, ch_start, ch_end, app_en, wren}, 0);
    repeat (3) step();
    chk("one_start", n_start - s0, 1);
    chk("one_end", n_end - e0, 1);
  endtask

  initial begin
    int r0;
    repeat (3) step();
    chk("reset_outputs", {fifo_rden, ch_req, ch_start, ch_end, app_en, wren, wdf_end}, 0);
    chk("reset_addr", app_addr, 0);
    rst = 0;
    push_words(BL - 1);
    r0 = n_req;
    repeat (100) step();
    chk("no_req_at_63", n_req - r0, 0);
    push_words(1);
    run_burst(3, BL, -1, 0, 512);
    rdy_pct = 50; wdf_pct = 30;
    push_words(BL);
    run_burst(3, BL, -1, 512, 0);
    rdy_pct = 100; wdf_pct = 100;
    push_words(BL);
    run_burst(2, 10, -1, 0, 512);
    push_words(BL);
    run_burst(2, BL, 20, 512, 0);
    push_words(BL - fifo_q.size());
    run_burst(2, BL, -1, 0, 512);
    repeat (4) step();
    chk("cmd_queue_drained", exp_addr.size(), 0);
    chk("dat_queue_drained", exp_dat.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
